// File: rtl/cp0_pkg.sv
// CP0 shared definitions: register numbers, exception codes,
// Status/Cause field positions and MTC0 writable-bit masks.
package cp0_pkg;

  typedef enum logic [4:0] {
    REG_INDEX    = 5'd0,
    REG_RANDOM   = 5'd1,
    REG_WIRED    = 5'd6,
    REG_BADVADDR = 5'd8,
    REG_COUNT    = 5'd9,
    REG_ENTRYHI  = 5'd10,
    REG_COMPARE  = 5'd11,
    REG_STATUS   = 5'd12,
    REG_CAUSE    = 5'd13,
    REG_EPC      = 5'd14,
    REG_EBASE    = 5'd15
  } cp0_reg_e;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_MOD  = 5'd1,
    EXC_TLBL = 5'd2,
    EXC_TLBS = 5'd3,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_IBE  = 5'd6,
    EXC_DBE  = 5'd7,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_CPU  = 5'd11,
    EXC_OV   = 5'd12,
    EXC_TR   = 5'd13
  } exc_code_e;

  // Status fields
  localparam int unsigned ST_IE    = 0;
  localparam int unsigned ST_EXL   = 1;
  localparam int unsigned ST_IM_LO = 8;
  localparam int unsigned ST_IM_HI = 15;

  // Cause fields
  localparam int unsigned CA_EXC_LO = 2;
  localparam int unsigned CA_EXC_HI = 6;
  localparam int unsigned CA_IP_LO  = 8;
  localparam int unsigned CA_IP_HI  = 15;
  localparam int unsigned CA_TI     = 30;
  localparam int unsigned CA_BD     = 31;

  // EntryHi VPN2 field loaded on TLB exceptions
  localparam int unsigned ENTRYHI_VPN_LO = 13;

  localparam logic [31:0] STATUS_RST    = 32'h1000_0000;
  localparam logic [31:0] STATUS_WMASK  = 32'h1000_FF03;
  localparam logic [31:0] CAUSE_WMASK   = 32'h0000_0300;
  localparam logic [31:0] ENTRYHI_WMASK = 32'hFFFF_E0FF;
  localparam logic [31:0] EBASE_WMASK   = 32'h3FFF_F000;

  // Writable bits come from the new value, the rest from the old one
  function automatic logic [31:0] merge_w(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [31:0] mask);
    return (new_v & mask) | (old_v & ~mask);
  endfunction

  // Address-error and TLB exceptions record the faulting address
  function automatic logic sets_badvaddr(input logic [4:0] code);
    return (code >= EXC_MOD) && (code <= EXC_ADES);
  endfunction

  // TLB exceptions also load the VPN into EntryHi
  function automatic logic sets_entryhi(input logic [4:0] code);
    return (code >= EXC_MOD) && (code <= EXC_TLBS);
  endfunction

endpackage

// File: rtl/cp0_if.sv
// MTC0 write / MFC0 read bus between the pipeline and CP0.
interface cp0_if;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [4:0]  raddr_i;
  logic [31:0] rdata_o;

  modport master (output we_i, output waddr_i, output wdata_i,
                  output raddr_i, input rdata_o);
  modport slave  (input we_i, input waddr_i, input wdata_i,
                  input raddr_i, output rdata_o);
endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer: prescaled Count, Compare, and the TI flag.
module cp0_timer #(
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  localparam int unsigned   PW       = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(COUNT_DIV - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [31:0]   count_q, count_d;
  logic [31:0]   compare_q, compare_d;
  logic          ti_q, ti_d;

  // Next-state: prescaled Count, Compare load, TI set/clear
  always_comb begin
    pre_d     = pre_q;
    count_d   = count_q;
    compare_d = compare_q;
    ti_d      = ti_q;
    if (count_we_i) begin
      count_d = wdata_i;
      pre_d   = '0;
    end else if (pre_q == PRE_LAST) begin
      pre_d   = '0;
      count_d = count_q + 32'd1;
    end else begin
      pre_d   = pre_q + PW'(1);
    end
    if (compare_we_i) begin
      compare_d = wdata_i;
      ti_d      = 1'b0;
    end else if (count_q == compare_q) begin
      ti_d      = 1'b1;
    end
  end

  // Timer state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q     <= '0;
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_unit.sv
// MIPS32 system-control coprocessor: control registers, interrupt
// synchronisation and masking, TLB Random/Wired, exception/ERET updates.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter int unsigned TLB_ENTRIES = 16,
  parameter int unsigned HW_INT      = 6,
  parameter int unsigned COUNT_DIV   = 2,
  parameter logic [31:0] EBASE_RST   = 32'h8000_1000
) (
  input  logic                           clk,
  input  logic                           rst,
  cp0_if.slave                           bus,
  input  logic [HW_INT-1:0]              int_i,
  input  logic                           exc_valid_i,
  input  logic [4:0]                     exc_code_i,
  input  logic [31:0]                    exc_pc_i,
  input  logic                           exc_bd_i,
  input  logic [31:0]                    exc_badvaddr_i,
  input  logic                           eret_i,
  output logic                           int_req_o,
  output logic                           timer_int_o,
  output logic [31:0]                    status_o,
  output logic [31:0]                    cause_o,
  output logic [31:0]                    epc_o,
  output logic [31:0]                    ebase_o,
  output logic [$clog2(TLB_ENTRIES)-1:0] random_o
);

  localparam int unsigned      IDX_W    = $clog2(TLB_ENTRIES);
  localparam logic [IDX_W-1:0] RAND_TOP = IDX_W'(TLB_ENTRIES - 1);
  localparam logic [31:0]      IDX_MASK = 32'(TLB_ENTRIES - 1);

  logic [IDX_W-1:0]  index_q, index_d;
  logic [IDX_W-1:0]  wired_q, wired_d;
  logic [IDX_W-1:0]  random_q, random_d;
  logic [31:0]       badvaddr_q, badvaddr_d;
  logic [31:0]       entryhi_q, entryhi_d;
  logic [31:0]       status_q, status_d;
  logic [31:0]       epc_q, epc_d;
  logic [31:0]       ebase_q, ebase_d;
  logic              cause_bd_q, cause_bd_d;
  logic [1:0]        ip_sw_q, ip_sw_d;
  logic [4:0]        exc_q, exc_d;
  logic [HW_INT-1:0] sync1_q, sync2_q;

  logic [31:0] count, compare;
  logic        ti;
  logic [5:0]  hw_ip;
  logic [7:0]  ip;
  logic [31:0] cause;

  logic wr_index, wr_wired, wr_count, wr_entryhi, wr_compare;
  logic wr_status, wr_cause, wr_epc, wr_ebase;

  assign wr_index   = bus.we_i && (bus.waddr_i == REG_INDEX);
  assign wr_wired   = bus.we_i && (bus.waddr_i == REG_WIRED);
  assign wr_count   = bus.we_i && (bus.waddr_i == REG_COUNT);
  assign wr_entryhi = bus.we_i && (bus.waddr_i == REG_ENTRYHI);
  assign wr_compare = bus.we_i && (bus.waddr_i == REG_COMPARE);
  assign wr_status  = bus.we_i && (bus.waddr_i == REG_STATUS);
  assign wr_cause   = bus.we_i && (bus.waddr_i == REG_CAUSE);
  assign wr_epc     = bus.we_i && (bus.waddr_i == REG_EPC);
  assign wr_ebase   = bus.we_i && (bus.waddr_i == REG_EBASE);

  cp0_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clk          (clk),
    .rst_n        (rst),
    .count_we_i   (wr_count),
    .compare_we_i (wr_compare),
    .wdata_i      (bus.wdata_i),
    .count_o      (count),
    .compare_o    (compare),
    .ti_o         (ti)
  );

  // Two-flop synchroniser on the asynchronous interrupt lines
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= int_i;
      sync2_q <= sync1_q;
    end
  end

  // Map synchronised lines onto IP[7:2]; absent lines read as 0
  always_comb begin
    hw_ip = '0;
    for (int unsigned k = 0; k < HW_INT; k++) begin
      hw_ip[k] = sync2_q[k];
    end
  end

  assign ip = {hw_ip[5] | ti, hw_ip[4:0], ip_sw_q};

  // Assemble the architectural Cause value
  always_comb begin
    cause                      = '0;
    cause[CA_BD]               = cause_bd_q;
    cause[CA_TI]               = ti;
    cause[CA_IP_HI:CA_IP_LO]   = ip;
    cause[CA_EXC_HI:CA_EXC_LO] = exc_q;
  end

  // Next-state: MTC0 first, then ERET, then exception override per field
  always_comb begin
    index_d    = wr_index ? bus.wdata_i[IDX_W-1:0] : index_q;
    wired_d    = wr_wired ? bus.wdata_i[IDX_W-1:0] : wired_q;
    status_d   = wr_status  ? merge_w(status_q, bus.wdata_i, STATUS_WMASK)   : status_q;
    entryhi_d  = wr_entryhi ? merge_w(entryhi_q, bus.wdata_i, ENTRYHI_WMASK) : entryhi_q;
    ebase_d    = wr_ebase   ? merge_w(ebase_q, bus.wdata_i, EBASE_WMASK)     : ebase_q;
    epc_d      = wr_epc   ? bus.wdata_i : epc_q;
    ip_sw_d    = wr_cause ? bus.wdata_i[CA_IP_LO+1:CA_IP_LO] : ip_sw_q;
    badvaddr_d = badvaddr_q;
    cause_bd_d = cause_bd_q;
    exc_d      = exc_q;

    if (wr_wired || (random_q <= wired_q)) begin
      random_d = RAND_TOP;
    end else begin
      random_d = random_q - IDX_W'(1);
    end

    if (exc_valid_i) begin
      if (!status_q[ST_EXL]) begin
        epc_d      = exc_bd_i ? (exc_pc_i - 32'd4) : exc_pc_i;
        cause_bd_d = exc_bd_i;
      end
      status_d[ST_EXL] = 1'b1;
      exc_d            = exc_code_i;
      if (sets_badvaddr(exc_code_i)) begin
        badvaddr_d = exc_badvaddr_i;
      end
      if (sets_entryhi(exc_code_i)) begin
        entryhi_d[31:ENTRYHI_VPN_LO] = exc_badvaddr_i[31:ENTRYHI_VPN_LO];
      end
    end else if (eret_i) begin
      status_d[ST_EXL] = 1'b0;
    end
  end

  // Architectural register state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      index_q    <= '0;
      wired_q    <= '0;
      random_q   <= RAND_TOP;
      badvaddr_q <= '0;
      entryhi_q  <= '0;
      status_q   <= STATUS_RST;
      epc_q      <= '0;
      ebase_q    <= EBASE_RST;
      cause_bd_q <= 1'b0;
      ip_sw_q    <= '0;
      exc_q      <= '0;
    end else begin
      index_q    <= index_d;
      wired_q    <= wired_d;
      random_q   <= random_d;
      badvaddr_q <= badvaddr_d;
      entryhi_q  <= entryhi_d;
      status_q   <= status_d;
      epc_q      <= epc_d;
      ebase_q    <= ebase_d;
      cause_bd_q <= cause_bd_d;
      ip_sw_q    <= ip_sw_d;
      exc_q      <= exc_d;
    end
  end

  logic [31:0] rd_reg;
  logic [31:0] rd_mask;

  // MFC0 read mux; a same-cycle MTC0 to the read register is forwarded
  // through that register's writable mask
  always_comb begin
    rd_reg  = '0;
    rd_mask = '0;
    case (bus.raddr_i)
      REG_INDEX:    begin rd_reg = 32'(index_q);  rd_mask = IDX_MASK;      end
      REG_RANDOM:   begin rd_reg = 32'(random_q);                          end
      REG_WIRED:    begin rd_reg = 32'(wired_q);  rd_mask = IDX_MASK;      end
      REG_BADVADDR: begin rd_reg = badvaddr_q;                             end
      REG_COUNT:    begin rd_reg = count;         rd_mask = '1;            end
      REG_ENTRYHI:  begin rd_reg = entryhi_q;     rd_mask = ENTRYHI_WMASK; end
      REG_COMPARE:  begin rd_reg = compare;       rd_mask = '1;            end
      REG_STATUS:   begin rd_reg = status_q;      rd_mask = STATUS_WMASK;  end
      REG_CAUSE:    begin rd_reg = cause;         rd_mask = CAUSE_WMASK;   end
      REG_EPC:      begin rd_reg = epc_q;         rd_mask = '1;            end
      REG_EBASE:    begin rd_reg = ebase_q;       rd_mask = EBASE_WMASK;   end
      default:      begin rd_reg = '0;            rd_mask = '0;            end
    endcase
    if (bus.we_i && (bus.waddr_i == bus.raddr_i)) begin
      bus.rdata_o = merge_w(rd_reg, bus.wdata_i, rd_mask);
    end else begin
      bus.rdata_o = rd_reg;
    end
  end

  assign int_req_o   = status_q[ST_IE] & ~status_q[ST_EXL]
                     & (|(ip & status_q[ST_IM_HI:ST_IM_LO]));
  assign timer_int_o = ti;
  assign status_o    = status_q;
  assign cause_o     = cause;
  assign epc_o       = epc_q;
  assign ebase_o     = ebase_q;
  assign random_o    = random_q;

endmodule

// File: tb/tb_cp0_unit.sv
// Scoreboard bench for cp0_unit: a register-level reference model predicts
// every output each cycle; a negedge monitor pops and compares.
module tb_cp0_unit;

  localparam int unsigned TLB = 16;
  localparam int unsigned DIV = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  int_i;
  logic        exc_valid, exc_bd, eret;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc, exc_badv;
  logic        int_req, timer_int;
  logic [31:0] status, cause, epc, ebase;
  logic [3:0]  random_v;

  cp0_if bus();

  cp0_unit #(
    .TLB_ENTRIES (16),
    .HW_INT      (6),
    .COUNT_DIV   (2),
    .EBASE_RST   (32'h8000_1000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .int_i          (int_i),
    .exc_valid_i    (exc_valid),
    .exc_code_i     (exc_code),
    .exc_pc_i       (exc_pc),
    .exc_bd_i       (exc_bd),
    .exc_badvaddr_i (exc_badv),
    .eret_i         (eret),
    .int_req_o      (int_req),
    .timer_int_o    (timer_int),
    .status_o       (status),
    .cause_o        (cause),
    .epc_o          (epc),
    .ebase_o        (ebase),
    .random_o       (random_v)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] status, cause, epc, ebase, rdata;
    logic [3:0]  random;
    logic        int_req, ti;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // ---------------- reference model ----------------
  int unsigned m_index, m_wired, m_random, m_ccyc;
  logic [31:0] m_badv, m_entryhi, m_status, m_epc, m_ebase, m_cbase, m_compare;
  logic        m_bd, m_ti;
  logic [1:0]  m_ipsw;
  logic [4:0]  m_exc;
  logic [5:0]  m_h1, m_h2;

  function automatic logic [31:0] m_count();
    return m_cbase + 32'(m_ccyc / DIV);
  endfunction

  function automatic logic [7:0] m_ip();
    return {m_h2[5] | m_ti, m_h2[4:0], m_ipsw};
  endfunction

  function automatic logic [31:0] m_cause();
    return {m_bd, m_ti, 14'd0, m_ip(), 1'b0, m_exc, 2'b00};
  endfunction

  function automatic logic [31:0] m_reg(input logic [4:0] a);
    case (a)
      5'd0:    return 32'(m_index);
      5'd1:    return 32'(m_random);
      5'd6:    return 32'(m_wired);
      5'd8:    return m_badv;
      5'd9:    return m_count();
      5'd10:   return m_entryhi;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause();
      5'd14:   return m_epc;
      5'd15:   return m_ebase;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_wmask(input logic [4:0] a);
    case (a)
      5'd0, 5'd6:         return 32'(TLB - 1);
      5'd9, 5'd11, 5'd14: return 32'hFFFF_FFFF;
      5'd10:              return 32'hFFFF_E0FF;
      5'd12:              return 32'h1000_FF03;
      5'd13:              return 32'h0000_0300;
      5'd15:              return 32'h3FFF_F000;
      default:            return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] put(input logic [31:0] o, input logic [31:0] n,
                                      input logic [31:0] m);
    return (n & m) | (o & ~m);
  endfunction

  function automatic logic wr(input logic [4:0] a);
    return bus.we_i && (bus.waddr_i == a);
  endfunction

  function automatic exp_t m_expect();
    exp_t e;
    logic [31:0] r;
    e.status  = m_status;
    e.cause   = m_cause();
    e.epc     = m_epc;
    e.ebase   = m_ebase;
    e.random  = 4'(m_random);
    e.ti      = m_ti;
    e.int_req = m_status[0] & ~m_status[1] & (|(m_ip() & m_status[15:8]));
    r = m_reg(bus.raddr_i);
    if (bus.we_i && (bus.waddr_i == bus.raddr_i)) r = put(r, bus.wdata_i, m_wmask(bus.raddr_i));
    e.rdata = r;
    return e;
  endfunction

  task automatic m_reset();
    m_index = 0; m_wired = 0; m_random = TLB - 1; m_ccyc = 0;
    m_badv = '0; m_entryhi = '0; m_status = 32'h1000_0000; m_epc = '0;
    m_ebase = 32'h8000_1000; m_cbase = '0; m_compare = '0;
    m_bd = 1'b0; m_ti = 1'b0; m_ipsw = '0; m_exc = '0; m_h1 = '0; m_h2 = '0;
  endtask

  task automatic m_step();
    logic [31:0] wd;
    logic        exl;
    wd  = bus.wdata_i;
    exl = m_status[1];
    if (wr(5'd11)) m_ti = 1'b0;
    else if (m_count() == m_compare) m_ti = 1'b1;
    if (wr(5'd11)) m_compare = wd;
    if (wr(5'd9)) begin m_cbase = wd; m_ccyc = 0; end
    else m_ccyc++;
    if (wr(5'd6) || m_random <= m_wired) m_random = TLB - 1;
    else m_random = m_random - 1;
    if (wr(5'd6))  m_wired   = int'(wd) % TLB;
    if (wr(5'd0))  m_index   = int'(wd) % TLB;
    if (wr(5'd12)) m_status  = put(m_status, wd, 32'h1000_FF03);
    if (wr(5'd13)) m_ipsw    = wd[9:8];
    if (wr(5'd14)) m_epc     = wd;
    if (wr(5'd15)) m_ebase   = put(m_ebase, wd, 32'h3FFF_F000);
    if (wr(5'd10)) m_entryhi = put(m_entryhi, wd, 32'hFFFF_E0FF);
    if (exc_valid) begin
      if (!exl) begin
        m_epc = exc_bd ? exc_pc - 32'd4 : exc_pc;
        m_bd  = exc_bd;
      end
      m_status[1] = 1'b1;
      m_exc = exc_code;
      if (exc_code >= 5'd1 && exc_code <= 5'd5) m_badv = exc_badv;
      if (exc_code >= 5'd1 && exc_code <= 5'd3) m_entryhi[31:13] = exc_badv[31:13];
    end else if (eret) begin
      m_status[1] = 1'b0;
    end
    m_h2 = m_h1;
    m_h1 = int_i;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp_v);
    end
  endtask

  // Monitor: one expected snapshot per cycle, sampled on the falling edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("status",    status,            e.status);
      chk("cause",     cause,             e.cause);
      chk("epc",       epc,               e.epc);
      chk("ebase",     ebase,             e.ebase);
      chk("random",    32'(random_v),     32'(e.random));
      chk("timer_int", 32'(timer_int),    32'(e.ti));
      chk("int_req",   32'(int_req),      32'(e.int_req));
      chk("rdata",     bus.rdata_o,       e.rdata);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    if (!rst) m_reset();
    exp_q.push_back(m_expect());
    @(posedge clk);
    if (rst) m_step();
    else m_reset();
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra);
    bus.we_i = we; bus.waddr_i = wa; bus.wdata_i = wd; bus.raddr_i = ra;
    exc_valid = 1'b0; eret = 1'b0;
  endtask

  task automatic exc(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                     input logic [31:0] badv);
    exc_valid = 1'b1; exc_code = code; exc_pc = pc; exc_bd = bd; exc_badv = badv;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 5'd0, 32'd0, 5'(i % 16));
      step();
    end
  endtask

  logic [4:0] tbl [11] = '{5'd0, 5'd1, 5'd6, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15};

  task automatic rand_cycle();
    logic [4:0]  wa, ra;
    logic [31:0] wd;
    int unsigned k;
    k  = $urandom_range(0, 15);
    wa = (k < 11) ? tbl[k] : 5'($urandom_range(0, 31));
    k  = $urandom_range(0, 15);
    ra = (k < 11) ? tbl[k] : 5'($urandom_range(0, 31));
    wd = $urandom;
    if (wa == 5'd9  && $urandom_range(0, 1) == 1) wd = m_compare - $urandom_range(0, 6);
    if (wa == 5'd11 && $urandom_range(0, 1) == 1) wd = m_count() + $urandom_range(0, 6);
    drive($urandom_range(0, 2) == 0, wa, wd, ra);
    if ($urandom_range(0, 3) == 0) bus.raddr_i = wa;
    if ($urandom_range(0, 11) == 0)
      exc(5'($urandom_range(0, 13)), $urandom, 1'($urandom_range(0, 1)), $urandom);
    if ($urandom_range(0, 9) == 0) eret = 1'b1;
    if ($urandom_range(0, 7) == 0) int_i = 6'($urandom);
    step();
  endtask

  initial begin
    rst = 1'b0; int_i = '0;
    exc_code = '0; exc_pc = '0; exc_bd = 1'b0; exc_badv = '0;
    drive(1'b0, 5'd0, 32'd0, 5'd0);
    @(posedge clk); #1;

    // reset values, then release
    step(); nops(1);
    rst = 1'b1;
    nops(2);

    // timer interrupt
    drive(1'b1, 5'd11, 32'd5, 5'd11);          step();
    drive(1'b1, 5'd12, 32'h1000_8001, 5'd12);  step();
    for (int i = 0; i < 14; i++) begin drive(1'b0, 5'd0, 32'd0, 5'd13); step(); end
    drive(1'b1, 5'd11, 32'd200, 5'd13);        step();
    nops(2);

    // delay-slot exception, nested exception, ERET
    drive(1'b0, 5'd0, 32'd0, 5'd14); exc(5'd4, 32'h8000_0104, 1'b1, 32'h0000_1235); step();
    drive(1'b0, 5'd0, 32'd0, 5'd8);  step();
    drive(1'b0, 5'd0, 32'd0, 5'd14); exc(5'd2, 32'h9000_0000, 1'b0, 32'hABCD_E123); step();
    drive(1'b0, 5'd0, 32'd0, 5'd10); step();
    drive(1'b0, 5'd0, 32'd0, 5'd12); eret = 1'b1; step();

    // Random / Wired
    drive(1'b1, 5'd6, 32'd12, 5'd1); step();
    for (int i = 0; i < 10; i++) begin drive(1'b0, 5'd0, 32'd0, 5'd1); step(); end

    // MTC0 Status in the same cycle as a syscall
    drive(1'b1, 5'd12, 32'd0, 5'd12); exc(5'd8, 32'h8000_0200, 1'b0, 32'd0); step();
    drive(1'b0, 5'd0, 32'd0, 5'd12); eret = 1'b1; step();

    // interrupt synchroniser and Cause forwarding
    drive(1'b1, 5'd12, 32'h1000_1001, 5'd13); step();
    int_i[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin drive(1'b0, 5'd0, 32'd0, 5'd13); step(); end
    int_i[2] = 1'b0;
    for (int i = 0; i < 4; i++) begin drive(1'b0, 5'd0, 32'd0, 5'd13); step(); end
    drive(1'b1, 5'd13, 32'hFFFF_FFFF, 5'd13); step();
    nops(2);

    // randomized traffic
    for (int i = 0; i < 800; i++) rand_cycle();

    // asynchronous reset mid-operation
    drive(1'b0, 5'd0, 32'd0, 5'd9);
    rst = 1'b0; step(); step();
    rst = 1'b1; nops(4);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain: %0d snapshots left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cp0_unit.md
# cp0_unit

Parametrised system-control coprocessor (CP0) for the MIPS32 core: architectural control registers, a Count/Compare timer, synchronised hardware interrupts with a masked interrupt request, TLB Random/Wired handling, and precise exception/ERET state updates. It sits beside the MEM/WB stage: MTC0 writes and MFC0 reads arrive from the pipeline, and exception commits arrive from the exception unit. It drives `status_o`, `cause_o`, `epc_o` and `ebase_o` to the PC-redirect logic, and `int_req_o` back to the exception unit.

## Interface
- `TLB_ENTRIES`, 16: TLB size; power of two, 2..64. `IDX_W = $clog2(TLB_ENTRIES)`.
- `HW_INT`, 6: number of hardware interrupt lines, 1..6. Line k maps to Cause.IP[k+2].
- `COUNT_DIV`, 2: Count increments once every `COUNT_DIV` cycles; allowed values 1..16.
- `EBASE_RST`, 32'h8000_1000: reset value of EBase.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `we_i` in 1: MTC0 write strobe.
- `waddr_i` in 5: register number for the write.
- `wdata_i` in 32: write data.
- `raddr_i` in 5: register number for the MFC0 read.
- `rdata_o` out 32: read data; combinational, with forwarding.
- `int_i` in `HW_INT`: asynchronous level interrupt lines.
- `exc_valid_i` in 1: an exception commits this cycle.
- `exc_code_i` in 5: ExcCode of the committing exception.
- `exc_pc_i` in 32: PC of the faulting instruction.
- `exc_bd_i` in 1: the faulting instruction is in a delay slot.
- `exc_badvaddr_i` in 32: faulting address.
- `eret_i` in 1: ERET commits this cycle.
- `int_req_o` out 1: a pending, enabled interrupt exists.
- `timer_int_o` out 1: Cause.TI.
- `status_o`, `cause_o`, `epc_o`, `ebase_o` out 32 each: live register values.
- `random_o` out `IDX_W`: current Random value, used by TLBWR.

## Operation
- **Register map:**
  - 0 Index: bits [IDX_W-1:0] are writable.
  - 1 Random: read-only.
  - 6 Wired: bits [IDX_W-1:0] are writable.
  - 8 BadVAddr: read-only to MTC0.
  - 9 Count.
  - 10 EntryHi: bits [31:13] and [7:0] are writable.
  - 11 Compare.
  - 12 Status: bits 28, 15:8, 1, 0 are writable.
  - 13 Cause: only IP[9:8] are writable.
  - 14 EPC.
  - 15 EBase: bits [29:12] are writable.
  - Other numbers: reads return 0 and writes are ignored.
- **Reset values:**
  - Status = 32'h1000_0000.
  - Random = `TLB_ENTRIES-1`.
  - EBase = `EBASE_RST`.
  - All other registers and all outputs derived from them are 0. No X is ever assigned.
- **Count:** a prescaler counts 0..`COUNT_DIV-1`. Count increments when the prescaler wraps and wraps at 2^32. An MTC0 to Count loads the value and clears the prescaler.
- **Timer:**
  - TI sets on the edge that ends a cycle in which Count == Compare, provided Compare was not written in that cycle.
  - An MTC0 to Compare clears TI.
  - Cause.IP[7] = TI OR the synchronised line 5.
- **Interrupts:**
  - Each `int_i` bit passes through a 2-flop synchroniser, whose output is Cause.IP[k+2].
  - `int_req_o` = Status.IE & ~Status.EXL & |(Cause.IP & Status.IM).
- **Random:**
  - Decrements by 1 every cycle.
  - When it equals Wired, or falls below Wired, the next value is `TLB_ENTRIES-1`.
  - An MTC0 to Wired also forces Random to `TLB_ENTRIES-1`.
- **Exception commit** (`exc_valid_i`):
  - If EXL == 0: EPC = `exc_bd_i` ? `exc_pc_i`-4 : `exc_pc_i`, and Cause.BD = `exc_bd_i`. If EXL == 1, EPC and BD hold.
  - EXL is set to 1 and Cause.ExcCode = `exc_code_i`.
  - For codes 1 to 5 (Mod, TLBL, TLBS, AdEL, AdES), BadVAddr = `exc_badvaddr_i`.
  - For codes 1 to 3, EntryHi[31:13] = `exc_badvaddr_i[31:13]`.
- **ERET:** clears EXL.
- **Same-cycle priority:** exception > ERET > MTC0, resolved per field. A field not touched by the winner still takes the MTC0 value; Count/TI updates still apply.
- **Read forwarding:** if `we_i` is set and `waddr_i == raddr_i`, `rdata_o` returns the masked post-write value: writable bits from `wdata_i`, other bits from the register. Random and BadVAddr return the register value.

## Timing
- MTC0 effects are visible on outputs one cycle after the write edge.
- An `int_i` level is visible in Cause.IP, and in `int_req_o` if unmasked, after 2 rising edges.
- Exception and ERET updates take 1 cycle.
- `int_req_o` is combinational from registers and has no input-to-output path.
- Asserting `rst` mid-operation immediately returns every register, the prescaler and the synchronisers to their reset values.

## Structure
- Package `cp0_pkg` holds the CP0 register numbers, the ExcCode constants, the Status/Cause bit positions and the writable-bit masks.
- Sub-module `cp0_timer`: the Count prescaler, the Count and Compare registers, and TI generation.
- Everything else lives in `cp0_unit`.

## Test plan
1. **Reset values:** release `rst` → Status = 32'h1000_0000, EBase = 32'h8000_1000, Random = 15, all others 0.
2. **Timer interrupt:** `COUNT_DIV`=2; write Compare = 5, Status = 32'h1000_8001 →
   - TI = 1 and `int_req_o` = 1 about 10 cycles later;
   - a Compare write clears both.
3. **Delay-slot exception:** exception code 4, PC 32'h8000_0104, bd = 1, badvaddr 32'h1235 →
   - EPC = 32'h8000_0100, BD = 1, BadVAddr = 32'h1235, EXL = 1;
   - a second exception with EXL set leaves EPC unchanged.
4. **Random/Wired:** write Wired = 12 → Random runs 15, 14, 13, 12, 15, …
5. **Same-cycle conflict:** MTC0 Status = 0 in the same cycle as a syscall → EXL = 1 and all other Status bits = 0.
6. **Interrupt sync and read forwarding:**
   - `int_i[2]` pulse held 3 cycles → IP4 rises 2 edges after `int_i` rises;
   - MFC0 Cause during a write of 32'hFFFF_FFFF → IP[9:8] read as 1.
